// File: rtl/r200_dmem_resp.sv
// Purpose: data-memory responder for the r200 memory stage. It performs B/H/W loads and stores against an internal word array.
// Latency: resp_valid is high WAIT_STATES+1 cycles after the accept cycle. One request per WAIT_STATES+2 cycles.
// Backpressure: req_ready is low from accept through RESP. Responses cannot be stalled. Option: `R200_DMEM_ALIGN_CHECK_EN.
module r200_dmem_resp #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [AW+1:0]   addr_q;
   logic [31:0]     wdata_q;
   logic            resp_valid_q;
   logic [31:0]     resp_rdata_q;
   logic            resp_err_q;
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            hs;
   logic            enter_resp;
   logic            cur_we;
   logic [2:0]      cur_f3;
   logic [AW+1:0]   cur_addr;
   logic [31:0]     cur_wdata;
   logic [AW-1:0]   idx;
   logic [31:0]     old_word, wr_word, new_word, ld_data, rdata_d;
   logic [7:0]      bsel;
   logic [15:0]     hsel;
   logic [3:0]      be;
   logic            err_d;
   logic            wr_en;
   logic            unused_addr_hi;

   // Upper address bits wrap the array and are deliberately ignored.
   assign unused_addr_hi = ^req_addr[31:AW+2];

   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign hs         = req_valid && req_ready;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

   // Live request fields: with zero wait states the access happens on the accept edge itself.
   always_comb begin
      cur_we    = req_we;
      cur_f3    = req_func3;
      cur_addr  = req_addr[AW+1:0];
      cur_wdata = req_wdata;
      if (state_q != S_IDLE) begin
         cur_we    = we_q;
         cur_f3    = f3_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
      end
   end

   // Next-state logic and wait-state counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hs) begin
               if (WAIT_STATES == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
               cnt_d      = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Lane selection, store merge, load extraction/extension and error detection.
   always_comb begin
      idx      = cur_addr[AW+1:2];
      old_word = mem_q[idx];
      be       = 4'b1111;
      wr_word  = cur_wdata;
      ld_data  = old_word;
      bsel     = old_word[{cur_addr[1:0], 3'b000} +: 8];
      hsel     = old_word[{cur_addr[1], 4'b0000} +: 16];
      case (cur_f3[1:0])
         2'b00: begin
            be      = 4'b0001 << cur_addr[1:0];
            wr_word = {4{cur_wdata[7:0]}};
            ld_data = cur_f3[2] ? {24'd0, bsel} : {{24{bsel[7]}}, bsel};
         end
         2'b01: begin
            be      = cur_addr[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{cur_wdata[15:0]}};
            ld_data = cur_f3[2] ? {16'd0, hsel} : {{16{hsel[15]}}, hsel};
         end
         default: begin
            be      = 4'b1111;
            wr_word = cur_wdata;
            ld_data = old_word;
         end
      endcase
      for (int l = 0; l < 4; l++) begin
         new_word[8*l +: 8] = be[l] ? wr_word[8*l +: 8] : old_word[8*l +: 8];
      end
`ifdef R200_DMEM_ALIGN_CHECK_EN
      err_d = (cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11) ||
              ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
              ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
      err_d = 1'b0;
`endif
      wr_en   = enter_resp && cur_we && !err_d;
      rdata_d = (cur_we || err_d) ? 32'd0 : ld_data;
   end

   // State, counter and captured request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (hs) begin
            we_q    <= req_we;
            f3_q    <= req_func3;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
         end
      end
   end

   // One-cycle response registers, loaded on the edge that enters RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         resp_valid_q <= enter_resp;
         resp_rdata_q <= enter_resp ? rdata_d : 32'd0;
         resp_err_q   <= enter_resp && err_d;
      end
   end

   // Storage array: never reset, a store commits only on the RESP entry edge.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[idx] <= new_word;
      end
   end
endmodule

// File: tb/tb_r200_dmem_resp.sv
module tb_r200_dmem_resp;
   typedef struct {
      int          inst;
      int          edge_no;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [2:0]  req_we;
   logic [2:0]  req_func3 [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic [2:0]  resp_valid;
   logic [31:0] resp_rdata [3];
   logic [2:0]  resp_err;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                          F_BU = 3'b100, F_HU = 3'b101, F_X = 3'b110;

`ifdef R200_DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=3, instance 2: WAIT_STATES=0.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      r200_dmem_resp #(
         .DEPTH_WORDS(1024),
         .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 3 : 0)
      ) dut (
         .clk       (clk),
         .rst       (rst[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_func3 (req_func3[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .resp_valid(resp_valid[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_err  (resp_err[g])
      );
   end

   function automatic int ws(input int i);
      return (i == 0) ? 1 : (i == 1) ? 3 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the oldest expectation per instance and checks timing and data.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int   k;
         exp_t e;
         k = -1;
         for (int j = 0; j < sb.size(); j++) begin
            if (k < 0 && sb[j].inst == i) k = j;
         end
         if (resp_valid[i]) begin
            if (k < 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_resp inst%0d: got resp_valid=1 at edge %0d, expected none", i, cyc);
            end else begin
               e = sb[k];
               sb.delete(k);
               check($sformatf("resp_edge inst%0d", i), 32'(cyc), 32'(e.edge_no));
               check($sformatf("resp_rdata inst%0d", i), resp_rdata[i], e.rdata);
               check($sformatf("resp_err inst%0d", i), {31'd0, resp_err[i]}, {31'd0, e.err});
            end
         end else if (k >= 0 && sb[k].edge_no < cyc) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL missing_resp inst%0d: got no resp by edge %0d, expected at edge %0d",
                     i, cyc, sb[k].edge_no);
            sb.delete(k);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input int i, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err,
                        input bit push, input bit keep_valid, output int acc_edge);
      int   tries;
      exp_t e;
      tries = 0;
      acc_edge = -1;
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_func3[i] = f3;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      while (!req_ready[i] && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (!req_ready[i]) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL accept_timeout inst%0d: got req_ready=0, expected 1 within 50 cycles", i);
         req_valid[i] = 1'b0;
      end else begin
         acc_edge = cyc + 1;
         if (push) begin
            e.inst    = i;
            e.edge_no = cyc + 1 + ws(i);
            e.rdata   = exp_rd;
            e.err     = exp_err;
            sb.push_back(e);
         end
         @(negedge clk);
         if (!keep_valid) req_valid[i] = 1'b0;
         req_addr[i]  = 32'hFFFF_FFFC;
         req_wdata[i] = 32'h5555_5555;
      end
   endtask

   task automatic drain(input int i);
      int tries;
      int n;
      tries = 0;
      do begin
         n = 0;
         foreach (sb[j]) if (sb[j].inst == i) n++;
         if (n != 0) begin
            @(negedge clk);
            tries++;
         end
      end while (n != 0 && tries < 100);
      if (n != 0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL drain_timeout inst%0d: got %0d pending, expected 0", i, n);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a_prev;
      rst       = 3'b111;
      req_valid = 3'b000;
      req_we    = 3'b000;
      for (int i = 0; i < 3; i++) begin
         req_func3[i] = F_W;
         req_addr[i]  = 32'd0;
         req_wdata[i] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ready inst%0d", i), {31'd0, req_ready[i]}, 32'd0);
         check($sformatf("rst_valid inst%0d", i), {31'd0, resp_valid[i]}, 32'd0);
         check($sformatf("rst_rdata inst%0d", i), resp_rdata[i], 32'd0);
         check($sformatf("rst_err inst%0d", i), {31'd0, resp_err[i]}, 32'd0);
      end
      rst = 3'b000;
      #1;
      for (int i = 0; i < 3; i++) check($sformatf("ready_after_rst inst%0d", i), {31'd0, req_ready[i]}, 32'd1);
      @(negedge clk);

      // WAIT_STATES=1: byte/half/word stores and loads with extension.
      issue(0, 1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 0, a);
      issue(0, 0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1, 0, a);
      issue(0, 1, F_B,  32'h11, 32'h000000A5, 32'h0,        0, 1, 0, a);
      issue(0, 0, F_W,  32'h10, 32'h0,        32'hDEADA5EF, 0, 1, 0, a);
      issue(0, 0, F_B,  32'h11, 32'h0,        32'hFFFFFFA5, 0, 1, 0, a);
      issue(0, 0, F_BU, 32'h11, 32'h0,        32'h000000A5, 0, 1, 0, a);
      issue(0, 1, F_H,  32'h12, 32'h00008001, 32'h0,        0, 1, 0, a);
      issue(0, 0, F_H,  32'h12, 32'h0,        32'hFFFF8001, 0, 1, 0, a);
      issue(0, 0, F_HU, 32'h12, 32'h0,        32'h00008001, 0, 1, 0, a);
      issue(0, 0, F_W,  32'h10, 32'h0,        32'h8001A5EF, 0, 1, 0, a);
      // Misaligned and illegal-func3 accesses.
      issue(0, 0, F_X,  32'h10, 32'h0,        ALIGN ? 32'h0 : 32'h8001A5EF, ALIGN, 1, 0, a);
      issue(0, 0, F_W,  32'h13, 32'h0,        ALIGN ? 32'h0 : 32'h8001A5EF, ALIGN, 1, 0, a);
      issue(0, 0, F_HU, 32'h13, 32'h0,        ALIGN ? 32'h0 : 32'h00008001, ALIGN, 1, 0, a);
      issue(0, 1, F_W,  32'h13, 32'h0,        32'h0,                        ALIGN, 1, 0, a);
      issue(0, 0, F_W,  32'h10, 32'h0,        ALIGN ? 32'h8001A5EF : 32'h0, 0, 1, 0, a);
      drain(0);

      // WAIT_STATES=3: reset during the second WAIT cycle discards the store.
      issue(1, 1, F_W, 32'h20, 32'h0BADF00D, 32'h0, 0, 1, 0, a);
      drain(1);
      issue(1, 1, F_W, 32'h20, 32'h12345678, 32'h0, 0, 0, 0, a);
      @(negedge clk);
      rst[1] = 1'b1;
      #1;
      check("abort_ready_in_rst", {31'd0, req_ready[1]}, 32'd0);
      @(negedge clk);
      rst[1] = 1'b0;
      #1;
      check("abort_ready_after_rst", {31'd0, req_ready[1]}, 32'd1);
      repeat (6) @(negedge clk);
      issue(1, 0, F_W, 32'h20, 32'h0, 32'h0BADF00D, 0, 1, 0, a);
      drain(1);

      // WAIT_STATES=0: valid held high, accepts every 2 cycles, address wrap.
      issue(2, 1, F_W, 32'h1004, 32'hCAFEF00D, 32'h0, 0, 1, 1, a_prev);
      issue(2, 0, F_W, 32'h0004, 32'h0, 32'hCAFEF00D, 0, 1, 1, a);
      check("b2b_spacing_1", 32'(a - a_prev), 32'd2);
      a_prev = a;
      issue(2, 1, F_W, 32'h0004, 32'h11223344, 32'h0, 0, 1, 1, a);
      check("b2b_spacing_2", 32'(a - a_prev), 32'd2);
      a_prev = a;
      issue(2, 0, F_W, 32'h1004, 32'h0, 32'h11223344, 0, 1, 0, a);
      check("b2b_spacing_3", 32'(a - a_prev), 32'd2);
      drain(2);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/r200_dmem_resp.md
# r200_dmem_resp

Data-memory responder for the r200 pipeline: the target end of the memory-stage load/store interface. It accepts one request at a time through a valid/ready handshake and inserts a programmable number of wait states. It performs RISC-V byte, halfword and word accesses against an internal word-organised array, then returns a one-cycle response with sign- or zero-extended load data. It sits behind the core's memory stage; the core stalls on `req_ready`/`resp_valid`.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, minimum 4.
- `WAIT_STATES`, default 1: extra cycles between accept and response; range 0..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_func3`  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned or illegal access; see Configuration.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1. A handshake (`req_valid` & `req_ready`) captures we, func3, addr and wdata. It then goes to WAIT with counter = `WAIT_STATES`, or directly to RESP if `WAIT_STATES` = 0.
  - WAIT: `req_ready` = 0. The counter decrements each cycle. At counter 1 the FSM goes to RESP.
  - RESP: `req_ready` = 0. `resp_valid`, `resp_rdata` and `resp_err` are valid this cycle only. The FSM returns to IDLE unconditionally; there is no response backpressure.
- The array access occurs on the edge that enters RESP. A store updates its byte lanes on that edge. A load reads the updated array, so store-then-load to the same address returns the new data.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so out-of-range addresses wrap.
- Byte lanes:
  - B/BU use lane `addr[1:0]`.
  - H/HU use lanes {2·`addr[1]`, 2·`addr[1]`+1}.
  - W uses all four lanes.
  - Stores write only the selected lanes from the low bits of wdata.
- Load extension: B/H sign-extend; BU/HU zero-extend; W passes through.
- Func3 011, 110 and 111 are treated as W.

## Timing
- Reset values: FSM in IDLE, counter 0, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0. `req_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Latency: for a request accepted at edge N, `resp_valid` is high in cycle N+1+`WAIT_STATES`.
- Throughput: one request per `WAIT_STATES`+2 cycles. The next accept occurs at the earliest in the IDLE cycle after RESP.
- Reset mid-operation:
  - Asserting `rst` in WAIT or RESP aborts the request and returns the FSM to IDLE.
  - A store not yet committed is discarded; no `resp_valid` is produced.
- Array contents are not reset; they hold their values across `rst`.
- `req_*` inputs are sampled only on the accept edge. Changes afterwards have no effect.

## Configuration
- `R200_DMEM_ALIGN_CHECK_EN`:
  - Defined: an access is an error if it is H/HU with `addr[0]` = 1, W with `addr[1:0]` ≠ 0, or uses func3 011/110/111. An error access:
    - asserts `resp_err` = 1 together with `resp_valid`;
    - returns `resp_rdata` = 0;
    - suppresses the store, leaving the array unchanged;
    - takes the same latency as a normal access.
  - Undefined: `resp_err` is tied to 0. Misaligned low address bits are masked: H ignores `addr[0]`, W ignores `addr[1:0]`. Illegal func3 values act as W.

## Test plan
- `WAIT_STATES`=1: SW 0x10 ← 0xDEADBEEF, then LW 0x10 → each `resp_valid` arrives 2 cycles after accept; rdata 0xDEADBEEF; store response rdata 0.
- SB 0x11 ← 0x000000A5, then LW 0x10 → 0xDEADA5EF; LB 0x11 → 0xFFFFFFA5; LBU 0x11 → 0x000000A5.
- SH 0x12 ← 0x00008001 → LH 0x12 returns 0xFFFF8001; LHU 0x12 returns 0x00008001; LW 0x10 returns 0x8001A5EF.
- LW 0x13 and SW 0x13 ← 0x0:
  - with macro → `resp_err`=1, rdata 0, word 0x10 unchanged;
  - without macro → LW returns word 0x10, SW overwrites word 0x10.
- `WAIT_STATES`=3: SW 0x20 ← 0x12345678 over prior value 0x0BADF00D, with `rst` pulsed in the second WAIT cycle → no `resp_valid`; `req_ready`=1 after release; LW 0x20 → 0x0BADF00D.
- `WAIT_STATES`=0, `req_valid` held high with alternating SW/LW to 0x4 and 0x1004 (`DEPTH_WORDS`=1024) → accepts every 2 cycles; `resp_valid` toggles 0/1; LW 0x4 returns data stored to 0x1004 (wrap-around).
